// File: rtl/uart_led_sensor_pkg.sv
// Shared constants, state types and helpers for the UART LED/sensor endpoint.
package uart_led_sensor_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_N  = 8'h4E;
    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_S  = 8'h53;

    localparam int RESP_LEN = 4;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;

    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
    endfunction

endpackage

// File: rtl/uart_led_sensor_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, mid-bit sampling FSM and stop-bit framing check.
module uart_led_sensor_rx
    import uart_led_sensor_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_byte
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state, next_state;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             sample;

    // rx_prev lags rx_sync by one cycle so a falling edge can be seen on clean data.
    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) state <= RX_IDLE;
        else        state <= next_state;
    end

    assign sample = (state == RX_START) ? (cnt == HALF_LAST)
                                        : ((state != RX_IDLE) && (cnt == FULL_LAST));

    always_comb begin
        next_state = state;
        case (state)
            RX_IDLE:  if (rx_prev && !rx_sync) next_state = RX_START;
            RX_START: if (sample) next_state = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample && bit_idx == 3'd7) next_state = RX_STOP;
            RX_STOP:  if (sample) next_state = RX_IDLE;
            default:  next_state = RX_IDLE;
        endcase
    end

    always_comb begin
        o_valid = (state == RX_STOP) && sample && rx_sync;
        o_byte  = shift;
    end

    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            if (state == RX_IDLE || sample) cnt <= '0;
            else                            cnt <= cnt + 1'b1;
            if (state == RX_START) begin
                bit_idx <= '0;
            end else if (state == RX_DATA && sample) begin
                bit_idx <= bit_idx + 1'b1;
                shift   <= {rx_sync, shift[7:1]};
            end
        end
    end

endmodule

// File: rtl/uart_led_sensor.sv
// UART command endpoint: ONd/OFd lines drive the LED bank, STATUS replies "S<hex><hex>\n"
// with a free-running synthetic sensor count.
module uart_led_sensor
    import uart_led_sensor_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int SENSOR_DIV  = 50_000,
    parameter int MAX_CMD_LEN = 8
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       FPGA_RXD,
    output logic       FPGA_TXD,
    output logic [7:0] o_LEDs
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int LEN_W  = $clog2(MAX_CMD_LEN + 1);
    localparam int IDX_W  = $clog2(MAX_CMD_LEN);
    localparam int DIV_W  = $clog2(SENSOR_DIV);
    localparam int BYTE_W = $clog2(RESP_LEN);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(RESP_LEN - 1);

    logic                         rx_valid;
    logic [7:0]                   rx_byte;
    logic [MAX_CMD_LEN-1:0][7:0]  cmd_buf, status_pat;
    logic [LEN_W-1:0]             cmd_len;
    logic                         overflow, line_done;
    logic                         digit_ok, is_on, is_off, is_status;
    logic [2:0]                   led_idx;
    logic [DIV_W-1:0]             sensor_div;
    logic [7:0]                   sensor, sensor_latched;
    logic                         resp_req;
    tx_state_t                    tx_state, tx_next;
    logic [CNT_W-1:0]             tx_cnt;
    logic                         tx_bit_done;
    logic [2:0]                   tx_bit;
    logic [BYTE_W-1:0]            tx_byte_idx;
    logic [7:0]                   tx_shift;

    function automatic logic [7:0] resp_byte(input logic [BYTE_W-1:0] idx, input logic [7:0] value);
        case (idx)
            BYTE_W'(0): return ASCII_S;
            BYTE_W'(1): return hex_ascii(value[7:4]);
            BYTE_W'(2): return hex_ascii(value[3:0]);
            default:    return ASCII_LF;
        endcase
    endfunction

    uart_led_sensor_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_Clock (i_Clock),
        .i_Rst   (i_Rst),
        .i_rx    (FPGA_RXD),
        .o_valid (rx_valid),
        .o_byte  (rx_byte)
    );

    // Unused buffer slots are kept at zero so a whole-buffer compare matches exact length.
    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) begin
            cmd_buf   <= '0;
            cmd_len   <= '0;
            overflow  <= 1'b0;
            line_done <= 1'b0;
        end else begin
            line_done <= rx_valid && (rx_byte == ASCII_LF);
            if (line_done) begin
                cmd_buf  <= '0;
                cmd_len  <= '0;
                overflow <= 1'b0;
            end else if (rx_valid && rx_byte != ASCII_CR && rx_byte != ASCII_LF) begin
                if (cmd_len < LEN_W'(MAX_CMD_LEN)) begin
                    cmd_buf[cmd_len[IDX_W-1:0]] <= rx_byte;
                    cmd_len <= cmd_len + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        status_pat    = '0;
        status_pat[0] = "S";
        status_pat[1] = "T";
        status_pat[2] = "A";
        status_pat[3] = "T";
        status_pat[4] = "U";
        status_pat[5] = "S";
        digit_ok  = (cmd_buf[2] >= 8'h31) && (cmd_buf[2] <= 8'h38);
        led_idx   = cmd_buf[2][2:0] - 3'd1;
        is_on     = line_done && !overflow && (cmd_len == LEN_W'(3)) &&
                    (cmd_buf[0] == ASCII_O) && (cmd_buf[1] == ASCII_N) && digit_ok;
        is_off    = line_done && !overflow && (cmd_len == LEN_W'(3)) &&
                    (cmd_buf[0] == ASCII_O) && (cmd_buf[1] == ASCII_F) && digit_ok;
        is_status = line_done && !overflow && (cmd_len == LEN_W'(6)) && (cmd_buf == status_pat);
    end

    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst)      o_LEDs <= 8'h00;
        else if (is_on)  o_LEDs[led_idx] <= 1'b1;
        else if (is_off) o_LEDs[led_idx] <= 1'b0;
    end

    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) begin
            sensor_div <= '0;
            sensor     <= 8'h00;
        end else if (sensor_div == DIV_W'(SENSOR_DIV - 1)) begin
            sensor_div <= '0;
            sensor     <= sensor + 1'b1;
        end else begin
            sensor_div <= sensor_div + 1'b1;
        end
    end

    // A STATUS arriving while a reply is queued or in flight is dropped.
    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) begin
            resp_req       <= 1'b0;
            sensor_latched <= 8'h00;
        end else if (is_status && tx_state == TX_IDLE && !resp_req) begin
            resp_req       <= 1'b1;
            sensor_latched <= sensor;
        end else if (tx_state == TX_LOAD) begin
            resp_req <= 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    assign tx_bit_done = (tx_cnt == FULL_LAST);

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (resp_req) tx_next = TX_LOAD;
            TX_LOAD:  tx_next = TX_START;
            TX_START: if (tx_bit_done) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_done && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_done) tx_next = (tx_byte_idx == LAST_BYTE) ? TX_IDLE : TX_START;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        case (tx_state)
            TX_START: FPGA_TXD = 1'b0;
            TX_DATA:  FPGA_TXD = tx_shift[0];
            default:  FPGA_TXD = 1'b1;
        endcase
    end

    // The next reply byte is loaded at the end of STOP so bytes go out back to back.
    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) begin
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_byte_idx <= '0;
            tx_shift    <= 8'hFF;
        end else begin
            if (tx_state == TX_IDLE || tx_state == TX_LOAD || tx_bit_done) tx_cnt <= '0;
            else                                                          tx_cnt <= tx_cnt + 1'b1;
            case (tx_state)
                TX_LOAD: begin
                    tx_byte_idx <= '0;
                    tx_bit      <= '0;
                    tx_shift    <= resp_byte('0, sensor_latched);
                end
                TX_DATA: if (tx_bit_done) begin
                    tx_bit   <= tx_bit + 1'b1;
                    tx_shift <= {1'b1, tx_shift[7:1]};
                end
                TX_STOP: if (tx_bit_done && tx_byte_idx != LAST_BYTE) begin
                    tx_byte_idx <= tx_byte_idx + 1'b1;
                    tx_shift    <= resp_byte(tx_byte_idx + BYTE_W'(1), sensor_latched);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_led_sensor.sv
`timescale 1ns/1ps
// Directed bench for uart_led_sensor at a scaled-down bit rate (16 clocks/bit) and sensor divider (400).
module tb_uart_led_sensor;

    localparam int CLK_FREQ    = 1_600_000;
    localparam int BAUD_RATE   = 100_000;
    localparam int SENSOR_DIV  = 400;
    localparam int MAX_CMD_LEN = 8;
    localparam int CPB         = CLK_FREQ / BAUD_RATE;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd   = 1'b1;
    logic       txd;
    logic [7:0] leds;
    int         checks = 0;
    int         failures = 0;
    int         since_reset = 0;
    logic       started;

    uart_led_sensor #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_RATE   (BAUD_RATE),
        .SENSOR_DIV  (SENSOR_DIV),
        .MAX_CMD_LEN (MAX_CMD_LEN)
    ) dut (
        .i_Clock  (clock),
        .i_Rst    (rst_n),
        .FPGA_RXD (rxd),
        .FPGA_TXD (txd),
        .o_LEDs   (leds)
    );

    always #5 clock = ~clock;

    // Clock count since reset release, used to place STATUS inside a known sensor window.
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) since_reset <= 0;
        else        since_reset <= since_reset + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        @(negedge clock);
        rxd = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (CPB) @(negedge clock);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clock);
        rxd = 1'b1;
    endtask

    task automatic send_line(input string text);
        for (int i = 0; i < text.len(); i++) applyStimulus(text[i], 1'b1);
        applyStimulus(8'h0A, 1'b1);
    endtask

    task automatic send_and_check(input string text, input logic [7:0] expected_leds);
        send_line(text);
        checkOutput({"leds_after_", text}, {24'd0, leds}, {24'd0, expected_leds});
    endtask

    task automatic wait_tx_start(output logic seen);
        int waited;
        waited = 0;
        while (txd !== 1'b0 && waited < 4000) begin
            @(negedge clock);
            waited++;
        end
        seen = (txd === 1'b0);
    endtask

    task automatic recv_byte(output logic [7:0] data, output logic ok);
        logic seen;
        data = 8'h00;
        ok   = 1'b0;
        wait_tx_start(seen);
        if (seen) begin
            repeat (CPB / 2) @(negedge clock);
            if (txd === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    data[i] = txd;
                end
                repeat (CPB) @(negedge clock);
                ok = (txd === 1'b1);
            end
        end
    endtask

    task automatic recv_response(input string tag, input logic [31:0] expected_bytes);
        logic [7:0] data;
        logic       ok;
        for (int i = 0; i < 4; i++) begin
            recv_byte(data, ok);
            checkOutput($sformatf("%s_byte%0d", tag, i), {23'd0, ok, data},
                        {23'd0, 1'b1, expected_bytes[31-8*i -: 8]});
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start, %0d clocks per bit", CPB);
        rst_n = 1'b0;
        rxd   = 1'b1;
        #100;
        checkOutput("reset_leds_held", {24'd0, leds}, 32'h00);
        checkOutput("reset_txd_held", {31'd0, txd}, 32'h1);
        rst_n = 1'b1;
        repeat (20) @(negedge clock);
        checkOutput("reset_leds_released", {24'd0, leds}, 32'h00);
        checkOutput("reset_txd_released", {31'd0, txd}, 32'h1);

        send_and_check("ON1", 8'h01);
        send_and_check("ON2", 8'h03);
        send_and_check("OF1", 8'h02);
        send_and_check("ON8", 8'h82);
        send_and_check("ON9", 8'h82);
        send_and_check("XYZ", 8'h82);
        send_and_check("on1", 8'h82);
        send_and_check("ON0", 8'h82);

        // A low pulse well under half a bit must be rejected as a false start.
        @(negedge clock);
        rxd = 1'b0;
        repeat (4) @(negedge clock);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        checkOutput("glitch_leds", {24'd0, leds}, 32'h82);

        // "ON5" with a bad stop bit on '5' leaves only "ON" in the buffer.
        applyStimulus("O", 1'b1);
        applyStimulus("N", 1'b1);
        applyStimulus("5", 1'b0);
        repeat (2 * CPB) @(negedge clock);
        applyStimulus(8'h0A, 1'b1);
        checkOutput("framing_leds", {24'd0, leds}, 32'h82);

        send_and_check("OF8\r", 8'h02);

        while (since_reset < 15884) @(negedge clock);
        fork
            send_line("STATUS");
            recv_response("status_2a", {8'h53, 8'h32, 8'h41, 8'h0A});
        join
        repeat (2 * CPB) @(negedge clock);
        checkOutput("txd_idle_after_status", {31'd0, txd}, 32'h1);

        send_and_check("ONXXXXXXXX1", 8'h02);
        send_and_check("", 8'h02);
        send_and_check("ON4", 8'h0A);

        fork
            send_line("STATUS");
            wait_tx_start(started);
        join
        checkOutput("reply_started", {31'd0, started}, 32'h1);
        repeat (3 * CPB + CPB / 2) @(negedge clock);
        checkOutput("reply_busy_bit2", {31'd0, txd}, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_txd", {31'd0, txd}, 32'h1);
        checkOutput("midreset_leds", {24'd0, leds}, 32'h00);
        repeat (10) @(negedge clock);
        rst_n = 1'b1;

        while (since_reset < 284) @(negedge clock);
        fork
            send_line("STATUS");
            recv_response("status_03", {8'h53, 8'h30, 8'h33, 8'h0A});
        join
        repeat (2 * CPB) @(negedge clock);
        checkOutput("final_leds", {24'd0, leds}, 32'h00);
        checkOutput("final_txd", {31'd0, txd}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_led_sensor.md
Name: uart_led_sensor

Overview:
- Top-level UART command endpoint: receives ASCII command lines on FPGA_RXD and drives 8 LEDs.
- On a STATUS request it transmits an internal sensor reading on FPGA_TXD.
- Sits between the board's WiFi/serial bridge pins and the LED bank.
- Sensor is an internal synthetic source (free-running sample counter); no external sensor pins.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate, 8N1 framing.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (434), clocks per UART bit; integer division.
- SENSOR_DIV, 50_000, clocks between sensor sample increments (1 ms).
- MAX_CMD_LEN, 8, command buffer depth in characters.

Ports:
- i_Clock  in  1  system clock, rising edge.
- i_Rst  in  1  asynchronous, active-low reset (0 = reset).
- FPGA_RXD  in  1  UART receive line, idle high, asynchronous to i_Clock.
- FPGA_TXD  out  1  UART transmit line, idle high.
- o_LEDs  out  8  LED drive, bit k = LED k+1, 1 = on.

Behaviour:
- Reset state: o_LEDs=8'h00, FPGA_TXD=1, receiver idle, command buffer empty, sensor=8'h00, transmitter idle.
- RX input path: FPGA_RXD passes through a 2-FF synchronizer before use.
- RX start detection: falling edge starts reception; the line is re-checked at CLKS_PER_BIT/2.
  - If high at that point: false start, return to idle.
- RX sampling: 8 data bits LSB first, each sampled at mid-bit (CLKS_PER_BIT intervals); stop bit sampled at mid-bit.
- RX byte handling:
  - Stop bit = 0: framing error, byte discarded.
  - Otherwise a 1-cycle rx_valid pulse with rx_byte.
- Line assembly from received bytes:
  - 0x0D is ignored.
  - 0x0A terminates the line and triggers the parse.
  - Any other byte is appended if count < MAX_CMD_LEN.
  - On a 9th character the line is marked overflow; it is discarded at the next 0x0A and the buffer cleared.
- Parse: one clock after the terminating 0x0A; buffer cleared the same cycle. Case-sensitive, exact length:
  - "ONd" with d in '1'..'8': o_LEDs[d-'1'] <= 1; other bits unchanged.
  - "OFd" with d in '1'..'8': o_LEDs[d-'1'] <= 0.
  - "STATUS": latch the sensor value and request a response.
  - Anything else, including an empty line or digit '0'/'9': ignored, no reply.
- LED updates are visible on o_LEDs 1 cycle after parse (registered).
- Sensor: 8-bit counter increments every SENSOR_DIV clocks and wraps 0xFF->0x00.
- STATUS response: 4 bytes, "S", high hex nibble, low hex nibble, 0x0A.
  - Hex digits are uppercase ASCII ('0'-'9','A'-'F').
- TX framing: start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT clocks; back-to-back bytes with no idle gap.
- TX FSM: IDLE -> LOAD -> START -> DATA(x8) -> STOP -> next byte or IDLE.
- STATUS while a response is still transmitting: ignored; the current response completes unaltered.
- Duplex: RX is fully independent of TX (full duplex); commands parse while TX is busy.
- Mid-operation reset: asserting i_Rst at any time aborts RX/TX immediately, TXD=1 and LEDs cleared asynchronously.

Decomposition:
- Shared package holds:
  - ASCII constants: 0x0A, 0x0D, 'O','N','F','S'.
  - Response length (4).
  - CLKS_PER_BIT computation.
  - The TX state enumeration.
- uart_rx is the one natural sub-module.
  - Interface: i_Clock, i_Rst, i_rx, o_valid, o_byte.
  - Contains the synchronizer, FSM and framing check.
- Line buffer, parser, sensor counter and TX serializer stay in the top.

Test Plan:
- Reset: hold i_Rst=0 for 100 ns, then release -> o_LEDs=8'h00 and FPGA_TXD=1, stable with no activity.
- Send "ON1\n" then "ON2\n" at 115200 -> o_LEDs=8'h01, then 8'h03, each within 2 clocks of the stop-bit sample of 0x0A.
- Send "OF1\n" -> o_LEDs=8'h02; then "ON8\n" -> 8'h82; then "ON9\n", "XYZ\n" and "on1\n" -> o_LEDs unchanged at 8'h82.
- Send "STATUS\n" after sensor forced/counted to 0x2A -> FPGA_TXD emits 0x53,0x32,0x41,0x0A, decoded at 8.68 us/bit, complete in about 347 us.
- Glitch: a 200 ns low pulse on FPGA_RXD -> no byte received, no LED change. Byte with stop bit 0 -> discarded.
- Overflow and reset:
  - "ONXXXXXXXX1\n" -> ignored.
  - Assert i_Rst during a STATUS reply -> TXD=1 immediately, LEDs 8'h00, next STATUS replies normally.
